wb_bus_if: RTL and testbench

Bridges one OpenMIPS core memory port (instruction ROM port or data RAM port) to a Wishbone B3 classic master bus.
- Sits directly downstream of the core: consumes the core's single-cycle ce/addr/data/we/sel request.
- Runs a multi-cycle Wishbone handshake and raises a stall request until the transfer completes.
- Returns read data to the core on the cycle the pipeline resumes.
- Two instances per core: one for the instruction port, one for the data port.

---
 rtl/wb_bus_if.sv | 194 +++++++++++++++++++
 tb/tb_wb_bus_if.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_if.sv
// wb_bus_if: OpenMIPS memory port to Wishbone B3 classic master.
// Optional BUS_TIMEOUT_EN aborts BUSY after TIMEOUT_CYCLES.
module wb_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq,
  input  logic [DATA_W-1:0]   wishbone_data_i,
  input  logic                wishbone_ack_i,
  output logic [ADDR_W-1:0]   wishbone_addr_o,
  output logic [DATA_W-1:0]   wishbone_data_o,
  output logic                wishbone_we_o,
  output logic [DATA_W/8-1:0] wishbone_sel_o,
  output logic                wishbone_stb_o,
  output logic                wishbone_cyc_o,
  output logic                bus_err_o
);

  localparam int SEL_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

  logic              stalled;
  logic              to_hit;
  logic              bus_done;
  logic [DATA_W-1:0] rd_data;

  assign stalled = |stall_i;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  logic [7:0] to_cnt_q, to_cnt_d;

  assign to_hit = (state_q == S_BUSY) &&
                  !wishbone_ack_i &&
                  (to_cnt_q == TO_LIM);

  always_comb begin
    to_cnt_d = 8'd0;
    if (state_q == S_BUSY && !wishbone_ack_i && !to_hit)
      to_cnt_d = to_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= 8'd0;
    else      to_cnt_q <= to_cnt_d;
  end

  assign bus_err_o = to_hit;
`else
  assign to_hit    = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  assign bus_done = (state_q == S_BUSY) &&
                    (wishbone_ack_i || to_hit);

  assign rd_data = to_hit ? {DATA_W{1'b1}}
                          : wishbone_data_i;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_buf_d = rd_buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = '0;
          addr_d   = '0;
          wdata_d  = '0;
          rd_buf_d = '0;
          state_d  = S_IDLE;
        end else if (bus_done) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          if (!we_q)
            rd_buf_d = rd_data;
          state_d = stalled ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          rd_buf_d = '0;
          state_d  = S_IDLE;
        end else if (!stalled) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cyc_d    = 1'b0;
        stb_d    = 1'b0;
        we_d     = 1'b0;
        sel_d    = '0;
        addr_d   = '0;
        wdata_d  = '0;
        rd_buf_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  always_comb begin
    stallreq = 1'b0;
    unique case (state_q)
      S_IDLE:  stallreq = cpu_ce_i && !flush_i;
      S_BUSY:  stallreq = !bus_done;
      default: stallreq = 1'b0;
    endcase
  end

  always_comb begin
    cpu_data_o = '0;
    if (bus_done && !we_q)
      cpu_data_o = rd_data;
    else if (state_q == S_WAIT)
      cpu_data_o = rd_buf_q;
  end

  assign wishbone_cyc_o  = cyc_q;
  assign wishbone_stb_o  = stb_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = wdata_q;

endmodule

// File: tb/tb_wb_bus_if.sv
// tb_wb_bus_if: scoreboard bench for wb_bus_if.
// Expected read data is queued at request time and popped on completion.
`timescale 1ns/1ps
module tb_wb_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic [31:0] wishbone_data_i = '0;
  logic        wishbone_ack_i = 1'b0;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
  logic        bus_err_o;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd_model = '0;
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  wb_bus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i),
    .cpu_data_o(cpu_data_o),
    .stallreq(stallreq),
    .wishbone_data_i(wishbone_data_i),
    .wishbone_ack_i(wishbone_ack_i),
    .wishbone_addr_o(wishbone_addr_o),
    .wishbone_data_o(wishbone_data_o),
    .wishbone_we_o(wishbone_we_o),
    .wishbone_sel_o(wishbone_sel_o),
    .wishbone_stb_o(wishbone_stb_o),
    .wishbone_cyc_o(wishbone_cyc_o),
    .bus_err_o(bus_err_o)
  );

  task automatic req(input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_sel_i  = s;
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_underflow got empty queue want entry");
      checks++;
      exp_v = 'x;
    end else begin
      exp_v = exp_q.pop_front();
      rd_model = exp_v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_ce_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o,
         wishbone_addr_o, wishbone_data_o} !== '0)
      $display("FAIL reset_bus got cyc=%b stb=%b addr=%h want all 0",
               wishbone_cyc_o, wishbone_stb_o, wishbone_addr_o);
    else passed++;
    checks++;
    if ({bus_err_o, cpu_data_o} !== '0)
      $display("FAIL reset_out got err=%b data=%h want 0 0",
               bus_err_o, cpu_data_o);
    else passed++;
    cpu_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_wait3();
    @(negedge clk);
    req(1'b0, 32'h0000_0100, '0, 4'hF);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if (stallreq !== 1'b1)
      $display("FAIL rd_req_stall got %b want 1", stallreq);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cpu_ce_i = 1'b0;
      wishbone_ack_i  = (k == 2);
      wishbone_data_i = (k == 2) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      checks++;
      if ({wishbone_cyc_o, wishbone_stb_o, wishbone_addr_o}
          !== {2'b11, 32'h100})
        $display("FAIL rd_bus%0d got cyc=%b addr=%h want 1 100",
                 k, wishbone_cyc_o, wishbone_addr_o);
      else passed++;
      checks++;
      if (stallreq !== (k != 2))
        $display("FAIL rd_stall%0d got %b want %b",
                 k, stallreq, (k != 2));
      else passed++;
      if (k == 2) begin
        pop_exp();
        checks++;
        if (cpu_data_o !== exp_v)
          $display("FAIL rd_data got %h want %h", cpu_data_o, exp_v);
        else passed++;
      end
    end
    @(negedge clk);
    wishbone_ack_i = 1'b0;
    #1;
    checks++;
    if ({wishbone_cyc_o, stallreq, cpu_data_o} !== '0)
      $display("FAIL rd_after got cyc=%b stall=%b data=%h want 0",
               wishbone_cyc_o, stallreq, cpu_data_o);
    else passed++;
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    req(1'b1, 32'h0000_0203, 32'h0000_00AB, 4'b0001);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cpu_ce_i = 1'b0;
      wishbone_ack_i = (k == 1);
      wishbone_data_i = 32'h5A5A_5A5A;
      #1;
      checks++;
      if ({wishbone_we_o, wishbone_sel_o, wishbone_data_o,
           wishbone_addr_o} !== {1'b1, 4'b0001, 32'hAB, 32'h203})
        $display("FAIL wr_bus%0d got we=%b sel=%b data=%h want 1 0001 ab",
                 k, wishbone_we_o, wishbone_sel_o, wishbone_data_o);
      else passed++;
      checks++;
      if (cpu_data_o !== 32'h0)
        $display("FAIL wr_cpu_data%0d got %h want 0", k, cpu_data_o);
      else passed++;
    end
    @(negedge clk);
    wishbone_ack_i = 1'b0;
    #1;
    checks++;
    if ({wishbone_cyc_o, wishbone_we_o, stallreq, cpu_data_o} !== '0)
      $display("FAIL wr_idle got cyc=%b we=%b data=%h want 0",
               wishbone_cyc_o, wishbone_we_o, cpu_data_o);
    else passed++;
  endtask

  task automatic test_ack_stalled();
    @(negedge clk);
    stall_i = 6'b000011;
    req(1'b0, 32'h0000_0300, '0, 4'hF);
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b1;
    wishbone_data_i = 32'h1234_5678;
    pop_exp();
    #1;
    checks++;
    if (cpu_data_o !== exp_v)
      $display("FAIL stl_ack_data got %h want %h", cpu_data_o, exp_v);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wishbone_ack_i = 1'b0;
      wishbone_data_i = 32'h0BAD_0BAD;
      if (k == 2) stall_i = '0;
      #1;
      checks++;
      if ({cpu_data_o, stallreq, wishbone_cyc_o}
          !== {rd_model, 2'b00})
        $display("FAIL stl_wait%0d got data=%h stall=%b want %h 0",
                 k, cpu_data_o, stallreq, rd_model);
      else passed++;
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_data_o, stallreq} !== '0)
      $display("FAIL stl_idle got data=%h stall=%b want 0",
               cpu_data_o, stallreq);
    else passed++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    req(1'b0, 32'h0000_0400, '0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cpu_ce_i = 1'b0;
      flush_i = (k == 1);
      #1;
      checks++;
      if ({wishbone_cyc_o, stallreq} !== 2'b11)
        $display("FAIL fl_busy%0d got cyc=%b stall=%b want 1 1",
                 k, wishbone_cyc_o, stallreq);
      else passed++;
    end
    rd_model = '0;
    @(negedge clk);
    flush_i = 1'b0;
    wishbone_ack_i = 1'b1;
    wishbone_data_i = 32'h5555_AAAA;
    #1;
    checks++;
    if ({wishbone_cyc_o, wishbone_stb_o, wishbone_addr_o,
         stallreq, cpu_data_o} !== '0)
      $display("FAIL fl_idle got cyc=%b addr=%h data=%h want 0",
               wishbone_cyc_o, wishbone_addr_o, cpu_data_o);
    else passed++;
    @(negedge clk);
    wishbone_ack_i = 1'b0;
    #1;
    checks++;
    if (wishbone_cyc_o !== 1'b0)
      $display("FAIL fl_ack_ignored got cyc=%b want 0", wishbone_cyc_o);
    else passed++;
    @(negedge clk);
    stall_i = 6'b000001;
    req(1'b1, 32'h0000_0404, 32'h1, 4'hF);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b1;
    @(negedge clk);
    wishbone_ack_i = 1'b0;
    #1;
    checks++;
    if (cpu_data_o !== rd_model)
      $display("FAIL fl_rdbuf got %h want %h", cpu_data_o, rd_model);
    else passed++;
    stall_i = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge clk);
    req(1'b0, 32'h0000_0500, '0, 4'hF);
    exp_q.push_back(32'hCAFE_0001);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    #1;
    checks++;
    if (wishbone_cyc_o !== 1'b1)
      $display("FAIL rm_busy got cyc=%b want 1", wishbone_cyc_o);
    else passed++;
    #1;
    rst = 1'b0;
    exp_q.delete();
    rd_model = '0;
    #1;
    checks++;
    if ({wishbone_cyc_o, wishbone_stb_o, wishbone_sel_o,
         wishbone_addr_o} !== '0)
      $display("FAIL rm_async got cyc=%b stb=%b addr=%h want 0",
               wishbone_cyc_o, wishbone_stb_o, wishbone_addr_o);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d = $urandom;
    req(1'b0, 32'h0000_0600, '0, 4'hF);
    exp_q.push_back(d);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b1;
    wishbone_data_i = d;
    pop_exp();
    #1;
    checks++;
    if ({wishbone_cyc_o, wishbone_addr_o, cpu_data_o}
        !== {1'b1, 32'h600, exp_v})
      $display("FAIL rm_clean got cyc=%b addr=%h data=%h want 1 600 %h",
               wishbone_cyc_o, wishbone_addr_o, cpu_data_o, exp_v);
    else passed++;
    @(negedge clk);
    wishbone_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wishbone_ack_i = 1'b0;
      d = $urandom;
      a = 32'h1000 + 32'(i * 4);
      req(1'b0, a, '0, 4'hF);
      exp_q.push_back(d);
      #1;
      checks++;
      if (stallreq !== 1'b1)
        $display("FAIL b2b_req%0d got stall=%b want 1", i, stallreq);
      else passed++;
      @(negedge clk);
      wishbone_ack_i = 1'b1;
      wishbone_data_i = d;
      pop_exp();
      #1;
      checks++;
      if ({wishbone_addr_o, cpu_data_o} !== {a, exp_v})
        $display("FAIL b2b_xfer%0d got addr=%h data=%h want %h %h",
                 i, wishbone_addr_o, cpu_data_o, a, exp_v);
      else passed++;
    end
    @(negedge clk);
    cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b0;
    #1;
    checks++;
    if (wishbone_cyc_o !== 1'b0)
      $display("FAIL b2b_end got cyc=%b want 0", wishbone_cyc_o);
    else passed++;
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    req(1'b0, 32'h0000_0700, '0, 4'hF);
    exp_q.push_back(32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cpu_ce_i = 1'b0;
      #1;
      checks++;
      if ({bus_err_o, stallreq, wishbone_cyc_o} !== 3'b011)
        $display("FAIL to_wait%0d got err=%b stall=%b want 0 1",
                 k, bus_err_o, stallreq);
      else passed++;
    end
    @(negedge clk);
    pop_exp();
    #1;
    checks++;
    if ({bus_err_o, stallreq, cpu_data_o} !== {2'b10, exp_v})
      $display("FAIL to_hit got err=%b stall=%b data=%h want 1 0 %h",
               bus_err_o, stallreq, cpu_data_o, exp_v);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({bus_err_o, wishbone_cyc_o} !== 2'b00)
      $display("FAIL to_after got err=%b cyc=%b want 0 0",
               bus_err_o, wishbone_cyc_o);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_wait3();
    test_byte_write();
    test_ack_stalled();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
